// File: rtl/mem_write_drain.sv
// Eviction-side write drain: queues evicted cache beats in a small FIFO, drains one
// beat per granted cycle into data memory, and forwards queued data to two read ports.
module mem_write_drain #(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_wen,
   input  logic [15:1]  in_waddr,
   input  logic [15:0]  in_wdata,
   output logic         stall,
   output logic         overflow,
   input  logic         mem_ready,
   output logic         out_wen,
   output logic [15:1]  out_waddr,
   output logic [15:0]  out_wdata,
   input  logic [15:1]  raddr0,
   output logic         hit0,
   output logic [15:0]  hdata0,
   input  logic [15:1]  raddr1,
   output logic         hit1,
   output logic [15:0]  hdata1
);

   // Handshake: a beat is accepted whenever in_wen=1 and the FIFO has room (or is
   // popping in the same cycle); the memory takes the head beat whenever out_wen=1,
   // which already includes mem_ready, so there is no separate acknowledge.

   logic              r_valid [DEPTH];
   logic [15:1]       r_addr  [DEPTH];
   logic [15:0]       r_data  [DEPTH];
   logic [PTRW-1:0]   r_head;
   logic [PTRW-1:0]   r_tail;
   logic [PTRW:0]     r_count;
   logic              r_overflow;

   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic [PTRW-1:0]   w_idx;
   logic              w_hit0;
   logic              w_hit1;
   logic [15:0]       w_hdata0;
   logic [15:0]       w_hdata1;

   assign w_full = (r_count == (PTRW+1)'(DEPTH));
   // Reset suppresses the strobe so no queued beat reaches memory in the reset cycle.
   assign w_pop  = !reset && (r_count != '0) && mem_ready;
   assign w_push = in_wen && (!w_full || w_pop);

   assign out_wen   = w_pop;
   assign out_waddr = w_pop ? r_addr[r_head] : '0;
   assign out_wdata = w_pop ? r_data[r_head] : '0;
   assign stall     = (r_count >= (PTRW+1)'(DEPTH-1));
   assign overflow  = r_overflow;

   // Scan oldest to newest so the most recently pushed match overrides older ones.
   always_comb begin
      w_idx    = '0;
      w_hit0   = 1'b0;
      w_hit1   = 1'b0;
      w_hdata0 = '0;
      w_hdata1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PTRW'(i);
         if (r_valid[w_idx] && (r_addr[w_idx] == raddr0)) begin
            w_hit0   = 1'b1;
            w_hdata0 = r_data[w_idx];
         end
         if (r_valid[w_idx] && (r_addr[w_idx] == raddr1)) begin
            w_hit1   = 1'b1;
            w_hdata1 = r_data[w_idx];
         end
      end
   end

   assign hit0   = w_hit0;
   assign hdata0 = w_hdata0;
   assign hit1   = w_hit1;
   assign hdata1 = w_hdata1;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_addr[i]  <= '0;
            r_data[i]  <= '0;
         end
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTRW'(1);
         end
         // When full, tail equals head; the push below must win over the pop's clear.
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_addr[r_tail]  <= in_waddr;
            r_data[r_tail]  <= in_wdata;
            r_tail          <= r_tail + PTRW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PTRW+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (PTRW+1)'(1);
         end
         if (in_wen && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_write_drain.sv
// Directed bench for mem_write_drain: drain latency, full/overflow, forwarding
// priority, push+pop when full, reset dominance and pointer wrap.
module tb_mem_write_drain;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_wen;
   logic [15:1]  in_waddr;
   logic [15:0]  in_wdata;
   logic         stall;
   logic         overflow;
   logic         mem_ready;
   logic         out_wen;
   logic [15:1]  out_waddr;
   logic [15:0]  out_wdata;
   logic [15:1]  raddr0;
   logic         hit0;
   logic [15:0]  hdata0;
   logic [15:1]  raddr1;
   logic         hit1;
   logic [15:0]  hdata1;

   int total = 0;
   int bad   = 0;
   logic [30:0] exp_q[$];

   always #5 clk = ~clk;

   mem_write_drain #(.DEPTH(4), .PTRW(2)) dut (
      .clk(clk), .reset(reset),
      .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
      .stall(stall), .overflow(overflow),
      .mem_ready(mem_ready),
      .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
      .raddr0(raddr0), .hit0(hit0), .hdata0(hdata0),
      .raddr1(raddr1), .hit1(hit1), .hdata1(hdata1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_wen = 1'b0; mem_ready = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   task automatic push(input logic [15:1] a, input logic [15:0] d);
      in_wen = 1'b1; in_waddr = a; in_wdata = d;
      cyc();
      in_wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int recv;
      reset = 1'b1; in_wen = 1'b0; in_waddr = '0; in_wdata = '0;
      mem_ready = 1'b0; raddr0 = '0; raddr1 = '0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      chk("rst out_wen", out_wen, 0);
      chk("rst stall", stall, 0);
      chk("rst overflow", overflow, 0);
      chk("rst hit0", hit0, 0);
      chk("rst hdata0", hdata0, 0);
      chk("rst hit1", hit1, 0);
      chk("rst hdata1", hdata1, 0);

      // 1: single beat, drained the cycle after it is pushed
      in_wen = 1'b1; in_waddr = 15'h0010; in_wdata = 16'hBEEF; mem_ready = 1'b1;
      #1;
      chk("t1 empty out_wen", out_wen, 0);
      cyc();
      in_wen = 1'b0;
      #1;
      chk("t1 out_wen", out_wen, 1);
      chk("t1 out_waddr", out_waddr, 32'h0010);
      chk("t1 out_wdata", out_wdata, 32'hBEEF);
      cyc();
      #1;
      chk("t1 idle out_wen", out_wen, 0);
      chk("t1 idle out_waddr", out_waddr, 0);
      chk("t1 idle out_wdata", out_wdata, 0);

      // 2: fill, stall threshold, overflow drop, ordered drain
      mem_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         push(15'(k), 16'hA000 + 16'(k));
         #1;
         chk("t2 stall", stall, (k >= 3) ? 1 : 0);
      end
      chk("t2 count full", dut.r_count, 4);
      chk("t2 overflow pre", overflow, 0);
      push(15'h0005, 16'hA005);
      #1;
      chk("t2 overflow", overflow, 1);
      chk("t2 count after drop", dut.r_count, 4);
      raddr0 = 15'h0005;
      #1;
      chk("t2 dropped not hit", hit0, 0);
      raddr0 = 15'h0001;
      #1;
      chk("t2 hit oldest", hit0, 1);
      chk("t2 hdata oldest", hdata0, 32'hA001);
      mem_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("t2 drain wen", out_wen, 1);
         chk("t2 drain addr", out_waddr, k);
         chk("t2 drain data", out_wdata, 32'hA000 + k);
         cyc();
      end
      #1;
      chk("t2 empty wen", out_wen, 0);
      chk("t2 empty stall", stall, 0);
      chk("t2 overflow sticky", overflow, 1);

      // 3: forwarding picks the newest of duplicate addresses
      do_reset();
      #1;
      chk("t3 overflow cleared", overflow, 0);
      push(15'h0020, 16'h1111);
      push(15'h0020, 16'h2222);
      raddr0 = 15'h0020; raddr1 = 15'h0021;
      #1;
      chk("t3 hit0", hit0, 1);
      chk("t3 hdata0", hdata0, 32'h2222);
      chk("t3 hit1", hit1, 0);
      chk("t3 hdata1", hdata1, 0);
      raddr1 = 15'h0020;
      in_wen = 1'b1; in_waddr = 15'h0030; in_wdata = 16'h3333; raddr0 = 15'h0030;
      #1;
      chk("t3 port1 hit", hit1, 1);
      chk("t3 port1 data", hdata1, 32'h2222);
      chk("t3 same-cycle not fwd", hit0, 0);
      in_wen = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("t3 pop head addr", out_waddr, 32'h0020);
      chk("t3 pop head data", out_wdata, 32'h1111);
      cyc();
      mem_ready = 1'b0;
      raddr0 = 15'h0020;
      #1;
      chk("t3 after pop hdata", hdata0, 32'h2222);

      // 4: push and pop together while full
      do_reset();
      for (int k = 0; k < 4; k++) push(15'h0040 + 15'(k), 16'hC000 + 16'(k));
      chk("t4 count full", dut.r_count, 4);
      mem_ready = 1'b1; in_wen = 1'b1; in_waddr = 15'h0044; in_wdata = 16'hC004;
      raddr0 = 15'h0040;
      #1;
      chk("t4 pop wen", out_wen, 1);
      chk("t4 pop addr", out_waddr, 32'h0040);
      chk("t4 popping still fwd", hit0, 1);
      cyc();
      in_wen = 1'b0; mem_ready = 1'b0;
      #1;
      chk("t4 count stays", dut.r_count, 4);
      chk("t4 overflow", overflow, 0);
      chk("t4 stall", stall, 1);
      chk("t4 old head gone", hit0, 0);
      raddr0 = 15'h0044;
      #1;
      chk("t4 new hit", hit0, 1);
      chk("t4 new hdata", hdata0, 32'hC004);
      mem_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("t4 drain addr", out_waddr, 32'h0040 + k);
         chk("t4 drain data", out_wdata, 32'hC000 + k);
         cyc();
      end

      // 5: reset dominates in_wen and mem_ready
      do_reset();
      for (int k = 0; k < 3; k++) push(15'h0050 + 15'(k), 16'hE000 + 16'(k));
      reset = 1'b1; in_wen = 1'b1; in_waddr = 15'h0060; in_wdata = 16'hE0E0; mem_ready = 1'b1;
      #1;
      chk("t5 wen during reset", out_wen, 0);
      cyc();
      reset = 1'b0; in_wen = 1'b0; raddr0 = 15'h0050; raddr1 = 15'h0060;
      #1;
      chk("t5 wen after reset", out_wen, 0);
      chk("t5 count", dut.r_count, 0);
      chk("t5 hit0", hit0, 0);
      chk("t5 hit1", hit1, 0);
      chk("t5 overflow", overflow, 0);

      // 6: pointer wrap with toggling grant
      do_reset();
      exp_q.delete();
      sent = 0; recv = 0;
      for (int c = 0; c < 80 && recv < 10; c++) begin
         mem_ready = c[0];
         in_wen = (sent < 10) && !stall;
         in_waddr = 15'h0100 + 15'(sent);
         in_wdata = 16'hD000 + 16'(sent);
         #1;
         if (out_wen) begin
            chk("t6 queue nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
               chk("t6 addr", out_waddr, exp_q[0][30:16]);
               chk("t6 data", out_wdata, exp_q[0][15:0]);
               void'(exp_q.pop_front());
            end
            recv++;
         end
         if (in_wen) begin
            exp_q.push_back({in_waddr, in_wdata});
            sent++;
         end
         cyc();
      end
      in_wen = 1'b0; mem_ready = 1'b0;
      #1;
      chk("t6 received all", recv, 10);
      chk("t6 no drop", overflow, 0);
      chk("t6 empty", dut.r_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
